// File: rtl/piano_key_conditioner.sv
// Piano key front-end: 2-flop sync, per-input debounce, priority note select, saturating octave FSM.
// Optional NOTE_HOLD_EN: keep the last selected note on the one-hot lines and note_code after release.
module piano_key_conditioner #(
  parameter int unsigned DEB_CYCLES = 16,
  parameter int unsigned DEB_W      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] key_raw,
  input  logic       oct_up_raw,
  input  logic       oct_dn_raw,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       a,
  output logic       b,
  output logic       up,
  output logic       down,
  output logic       note_active,
  output logic [2:0] note_code
);

  typedef enum logic [1:0] {OCT_LOW, OCT_MID, OCT_HIGH} oct_t;

  logic [8:0]       raw_in;
  logic [8:0]       sync1, sync2, deb;
  logic [DEB_W-1:0] cnt [9];
  logic [1:0]       oct_prev;
  logic             up_pulse, dn_pulse;
  logic [6:0]       sel_hot, note_hot;
  logic [2:0]       sel_code;
  logic             sel_found;
  oct_t             state, state_nxt;

  assign raw_in = {oct_dn_raw, oct_up_raw, key_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int unsigned i = 0; i < 9; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 9; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest-numbered pressed key wins.
  always_comb begin
    sel_hot   = '0;
    sel_code  = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      if (deb[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_hot   = 7'(1) << i;
        sel_code  = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_hot    <= '0;
      note_code   <= '0;
      note_active <= 1'b0;
    end else begin
      note_active <= sel_found;
`ifdef NOTE_HOLD_EN
      if (sel_found) begin
        note_hot  <= sel_hot;
        note_code <= sel_code;
      end
`else
      note_hot  <= sel_hot;
      note_code <= sel_code;
`endif
    end
  end

  assign {b, a, g, f, e, d, c} = note_hot;

  assign up_pulse = deb[7] & ~oct_prev[0];
  assign dn_pulse = deb[8] & ~oct_prev[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oct_prev <= '0;
      state    <= OCT_MID;
    end else begin
      oct_prev <= deb[8:7];
      state    <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (up_pulse != dn_pulse) begin
      case (state)
        OCT_LOW:  if (up_pulse) state_nxt = OCT_MID;
        OCT_MID:  state_nxt = up_pulse ? OCT_HIGH : OCT_LOW;
        OCT_HIGH: if (dn_pulse) state_nxt = OCT_MID;
        default:  state_nxt = OCT_MID;
      endcase
    end
  end

  assign up   = (state == OCT_HIGH);
  assign down = (state == OCT_LOW);

endmodule

// File: tb/tb_piano_key_conditioner.sv
// Self-checking bench for piano_key_conditioner: directed scenarios plus random stimulus against a window-based model.
module tb_piano_key_conditioner;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] key_raw;
  logic       oct_up_raw, oct_dn_raw;
  logic       c, d, e, f, g, a, b, up, down, note_active;
  logic [2:0] note_code;

  int n_cmp = 0;
  int n_bad = 0;

  piano_key_conditioner #(.DEB_CYCLES(16), .DEB_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw),
    .oct_up_raw(oct_up_raw), .oct_dn_raw(oct_dn_raw),
    .c(c), .d(d), .e(e), .f(f), .g(g), .a(a), .b(b),
    .up(up), .down(down), .note_active(note_active), .note_code(note_code)
  );

  always #5 clk = ~clk;

  // Reference model: a debounced bit flips once the synced input (raw two edges back)
  // has disagreed with it for the last DEB edges; octave is a clamped level 0..2.
  logic [8:0] hist[$];
  logic [8:0] m_deb, m_prev, m_new;
  logic [6:0] m_hot;
  logic [2:0] m_code;
  logic       m_act;
  int         m_lvl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_deb = '0; m_prev = '0; m_hot = '0; m_code = '0; m_act = 1'b0; m_lvl = 1;
    end else begin
      logic ue, de, flip, v;
      int idx, lowest;
      hist.push_back({oct_dn_raw, oct_up_raw, key_raw});
      lowest = -1;
      for (int k = 6; k >= 0; k--) if (m_deb[k]) lowest = k;
      m_act = (lowest >= 0);
      if (lowest >= 0) begin
        m_hot = '0; m_hot[lowest] = 1'b1; m_code = 3'(lowest + 1);
      end else begin
`ifndef NOTE_HOLD_EN
        m_hot = '0; m_code = '0;
`endif
      end
      ue = m_deb[7] & ~m_prev[7];
      de = m_deb[8] & ~m_prev[8];
      if (ue && !de && m_lvl < 2) m_lvl = m_lvl + 1;
      if (de && !ue && m_lvl > 0) m_lvl = m_lvl - 1;
      m_prev = m_deb;
      m_new  = m_deb;
      for (int bit_i = 0; bit_i < 9; bit_i++) begin
        flip = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          idx = hist.size() - 3 - j;
          v = (idx >= 0) ? hist[idx][bit_i] : 1'b0;
          if (v == m_deb[bit_i]) flip = 1'b0;
        end
        if (flip) m_new[bit_i] = ~m_deb[bit_i];
      end
      m_deb = m_new;
      if (hist.size() > DEB + 8) void'(hist.pop_front());
    end
  end

  function automatic logic [12:0] dut_vec();
    return {note_active, note_code, b, a, g, f, e, d, c, up, down};
  endfunction

  function automatic logic [12:0] mod_vec();
    return {m_act, m_code, m_hot, (m_lvl == 2), (m_lvl == 0)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    key_raw = '0; oct_up_raw = 1'b0; oct_dn_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_raw = '0; oct_up_raw = 1'b0; oct_dn_raw = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut_vec() !== 13'd0) begin n_bad++; $display("FAIL reset_init: got %h want 0", dut_vec()); end
    rst_n = 1'b1;
    key_raw = 7'h7F;
    repeat (25) @(negedge clk);
    n_cmp++;
    if ({c, note_code, note_active} !== {1'b1, 3'd1, 1'b1}) begin
      n_bad++; $display("FAIL reset_pre_press: got c=%b code=%0d act=%b want 1/1/1", c, note_code, note_active);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dut_vec() !== 13'd0) begin n_bad++; $display("FAIL reset_async: got %h want 0", dut_vec()); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL reset_relatency edge %0d: got %h want %h", i, dut_vec(), mod_vec()); end
      n_cmp++;
      if (c !== (i >= 19)) begin n_bad++; $display("FAIL reset_relatency_c edge %0d: got %b want %b", i, c, (i >= 19)); end
    end
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== 13'd0 || mod_vec() !== 13'd0) begin n_bad++; $display("FAIL reset_idle cyc %0d: got %h want 0", i, dut_vec()); end
    end
  endtask

  task automatic test_debounce_latency();
    @(negedge clk);
    key_raw = 7'b0000100;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL latency edge %0d: got %h want %h", i, dut_vec(), mod_vec()); end
      n_cmp++;
      if ({e, note_code} !== ((i >= 19) ? 4'b1_011 : 4'b0_000)) begin
        n_bad++; $display("FAIL latency_e edge %0d: got e=%b code=%0d want e=%b", i, e, note_code, (i >= 19));
      end
    end
    @(negedge clk);
    key_raw = '0;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL latency_rel cyc %0d: got %h want %h", i, dut_vec(), mod_vec()); end
    end
  endtask

  task automatic test_glitch();
    @(negedge clk);
    key_raw = 7'b0000100;
    for (int i = 0; i < 40; i++) begin
      if (i == 15) begin @(negedge clk); key_raw = '0; end
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== mod_vec() || e !== 1'b0 || note_code !== 3'd0) begin
        n_bad++; $display("FAIL glitch cyc %0d: got %h want %h (e=0)", i, dut_vec(), mod_vec());
      end
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    key_raw = 7'b1001010;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL priority cyc %0d: got %h want %h", i, dut_vec(), mod_vec()); end
    end
    n_cmp++;
    if ({b, a, g, f, e, d, c, note_code} !== {7'b0000010, 3'd2}) begin
      n_bad++; $display("FAIL priority_d: got lines=%b code=%0d want 0000010/2", {b, a, g, f, e, d, c}, note_code);
    end
    @(negedge clk);
    key_raw = 7'b1001000;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL priority_rel edge %0d: got %h want %h", i, dut_vec(), mod_vec()); end
      n_cmp++;
      if (note_code !== ((i >= 19) ? 3'd4 : 3'd2)) begin
        n_bad++; $display("FAIL priority_f edge %0d: got code=%0d want %0d", i, note_code, (i >= 19) ? 4 : 2);
      end
    end
    n_cmp++;
    if ({b, a, g, f, e, d, c} !== 7'b0001000) begin n_bad++; $display("FAIL priority_fline: got %b want 0001000", {b, a, g, f, e, d, c}); end
    @(negedge clk);
    key_raw = '0;
    repeat (22) @(posedge clk);
  endtask

  task automatic test_octave();
    logic [1:0] ev [7]  = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
    logic [1:0] exp [7] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      {oct_dn_raw, oct_up_raw} = ev[k];
      for (int i = 0; i < 44; i++) begin
        if (i == 22) begin @(negedge clk); oct_up_raw = 1'b0; oct_dn_raw = 1'b0; end
        @(posedge clk); #1;
        n_cmp++;
        if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL octave ev%0d cyc %0d: got %h want %h", k, i, dut_vec(), mod_vec()); end
      end
      n_cmp++;
      if ({up, down} !== exp[k]) begin n_bad++; $display("FAIL octave_state ev%0d: got up/down=%b want %b", k, {up, down}, exp[k]); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    @(negedge clk);
    oct_up_raw = 1'b1; oct_dn_raw = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({up, down} !== 2'b00 || dut_vec() !== mod_vec()) begin
        n_bad++; $display("FAIL simultaneous cyc %0d: got %h want %h (up=down=0)", i, dut_vec(), mod_vec());
      end
    end
    @(negedge clk);
    oct_up_raw = 1'b0; oct_dn_raw = 1'b0;
    repeat (22) @(posedge clk);
  endtask

  task automatic test_note_hold();
    @(negedge clk);
    key_raw = 7'b0100000;
    repeat (22) @(posedge clk);
    @(negedge clk);
    key_raw = '0;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL hold cyc %0d: got %h want %h", i, dut_vec(), mod_vec()); end
    end
    n_cmp++;
`ifdef NOTE_HOLD_EN
    if ({a, note_code, note_active} !== {1'b1, 3'd6, 1'b0}) begin
      n_bad++; $display("FAIL hold_a: got a=%b code=%0d act=%b want 1/6/0", a, note_code, note_active);
    end
`else
    if ({b, a, g, f, e, d, c, note_code, note_active} !== 11'd0) begin
      n_bad++; $display("FAIL hold_a: got a=%b code=%0d act=%b want 0/0/0", a, note_code, note_active);
    end
`endif
  endtask

  task automatic test_random();
    for (int s = 0; s < 60; s++) begin
      int len;
      @(negedge clk);
      key_raw    = 7'($urandom & $urandom & $urandom);
      oct_up_raw = ($urandom_range(0, 3) == 0);
      oct_dn_raw = ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (dut_vec() !== mod_vec()) begin n_bad++; $display("FAIL random seg %0d cyc %0d: got %h want %h", s, i, dut_vec(), mod_vec()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_priority();
    test_octave();
    test_simultaneous();
    test_note_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
